// File: rtl/serial_byte_tx_if.sv
// rtl/serial_byte_tx_if.sv - word-in / bit-out bus bundle for serial_byte_tx
//
// Purpose: groups the parallel word handshake and the serial output lane.
// Signals (direction as seen by the transmitter, modport slave):
//   i_data[DATA_W]  word to transmit, sampled on handshake
//   i_valid         i_data is valid
//   o_ready         transmitter can accept a word this cycle
//   o_ser           serial data bit
//   o_ser_valid     o_ser carries a valid bit
//   o_sof / o_eof   first / last bit of a frame
//   o_busy          a word is in flight
// The master modport is the upstream producer / downstream observer side.

interface serial_byte_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_ser;
    logic              o_ser_valid;
    logic              o_sof;
    logic              o_eof;
    logic              o_busy;

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_ser,
        output o_ser_valid,
        output o_sof,
        output o_eof,
        output o_busy
    );

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_ser,
        input  o_ser_valid,
        input  o_sof,
        input  o_eof,
        input  o_busy
    );
endinterface

// File: rtl/serial_byte_tx.sv
// rtl/serial_byte_tx.sv - parallel-to-serial word transmitter with frame strobes
//
// Purpose: accepts DATA_W-bit words on a valid/ready handshake and shifts them
// out one bit per clock, marking the first (o_sof) and last (o_eof) frame cycle.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   serial_byte_tx_if.slave (i_data, i_valid, o_ready, o_ser,
//            o_ser_valid, o_sof, o_eof, o_busy)
// Parameters: DATA_W (2..32), MSB_FIRST (1 = MSB shifted first).
// Optional feature: define SERIAL_BYTE_TX_PARITY_EN to append an even-parity
// bit after the data bits (frame becomes DATA_W+1 cycles).

module serial_byte_tx #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    serial_byte_tx_if.slave io_bus
);

    localparam int               CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
`ifdef SERIAL_BYTE_TX_PARITY_EN
        ,
        S_PAR   = 2'd2
`endif
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_ser;
    logic              r_ser_valid;
    logic              r_sof;
    logic              r_eof;
    logic              r_busy;
`ifdef SERIAL_BYTE_TX_PARITY_EN
    logic              r_par;
`endif

    logic              w_final;
    logic              w_ready;
    logic              w_accept;
    logic              w_first_bit;
    logic [DATA_W-1:0] w_load_shift;
    logic              w_head_bit;
    logic [DATA_W-1:0] w_next_shift;

    // The final frame cycle is the only in-frame cycle that may take a new word.
`ifdef SERIAL_BYTE_TX_PARITY_EN
    assign w_final = (r_state == S_PAR);
`else
    assign w_final = (r_state == S_SHIFT) && (r_cnt == LAST);
`endif

    assign w_ready  = i_rst_n && ((r_state == S_IDLE) || w_final);
    assign w_accept = io_bus.i_valid && w_ready;

    // The first bit goes straight to r_ser; r_shift keeps the remaining bits
    // aligned so that the next bit to send always sits at the head.
    assign w_first_bit  = MSB_FIRST ? io_bus.i_data[DATA_W-1] : io_bus.i_data[0];
    assign w_load_shift = MSB_FIRST ? {io_bus.i_data[DATA_W-2:0], 1'b0}
                                    : {1'b0, io_bus.i_data[DATA_W-1:1]};
    assign w_head_bit   = MSB_FIRST ? r_shift[DATA_W-1] : r_shift[0];
    assign w_next_shift = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0}
                                    : {1'b0, r_shift[DATA_W-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ser       <= 1'b0;
            r_ser_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SERIAL_BYTE_TX_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else if (w_accept) begin
            // Covers both the idle start and the gapless back-to-back start.
            r_state     <= S_SHIFT;
            r_cnt       <= '0;
            r_shift     <= w_load_shift;
            r_ser       <= w_first_bit;
            r_ser_valid <= 1'b1;
            r_sof       <= 1'b1;
            r_eof       <= 1'b0;
            r_busy      <= 1'b1;
`ifdef SERIAL_BYTE_TX_PARITY_EN
            r_par       <= ^io_bus.i_data;
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (r_cnt != LAST) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_shift <= w_next_shift;
                        r_ser   <= w_head_bit;
                        r_sof   <= 1'b0;
`ifdef SERIAL_BYTE_TX_PARITY_EN
                        r_eof   <= 1'b0;
`else
                        // Raise eof together with the bit that is about to be last.
                        r_eof   <= (r_cnt == LAST - 1'b1);
`endif
                    end else begin
`ifdef SERIAL_BYTE_TX_PARITY_EN
                        r_state <= S_PAR;
                        r_ser   <= r_par;
                        r_sof   <= 1'b0;
                        r_eof   <= 1'b1;
`else
                        r_state     <= S_IDLE;
                        r_cnt       <= '0;
                        r_shift     <= '0;
                        r_ser       <= 1'b0;
                        r_ser_valid <= 1'b0;
                        r_sof       <= 1'b0;
                        r_eof       <= 1'b0;
                        r_busy      <= 1'b0;
`endif
                    end
                end
                default: begin
                    // IDLE with no word, or the parity cycle ending without a successor.
                    r_state     <= S_IDLE;
                    r_cnt       <= '0;
                    r_shift     <= '0;
                    r_ser       <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_sof       <= 1'b0;
                    r_eof       <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.o_ready     = w_ready;
    assign io_bus.o_ser       = r_ser;
    assign io_bus.o_ser_valid = r_ser_valid;
    assign io_bus.o_sof       = r_sof;
    assign io_bus.o_eof       = r_eof;
    assign io_bus.o_busy      = r_busy;

endmodule
